noc_flit_rx_endpoint: RTL
=========================

Name: noc_flit_rx_endpoint

Overview:
Terminates one credit-based router output link and presents the received flits as an AXI-Stream master. It is the receiving end of the rtr-to-rtr flit protocol (data/dest/is_tail/send in, credit out). It buffers up to FLIT_BUFFER_DEPTH flits and returns one credit per flit drained. It sits between a router output port and a single-clock NoC-domain consumer, such as a traffic sink or a monitor on a mesh edge.

Parameters:
FLIT_WIDTH, 32, flit payload width; equals the axis_out_tdata width (no serialization).
TID_WIDTH, 2, width of axis_out_tid.
TDEST_WIDTH, 2, width of axis_out_tdest.
DEST_WIDTH, TID_WIDTH+TDEST_WIDTH, flit dest field width.
FLIT_BUFFER_DEPTH, 2, receive FIFO entries; the sender's initial credit count; must be ≥1.
PKT_CNT_WIDTH, 16, width of the completed-packet counter.

Ports:
clk_noc  in  1  NoC clock; all logic is on the rising edge.
rst_n  in  1  asynchronous active-low reset.
data_in  in  FLIT_WIDTH  flit payload.
dest_in  in  DEST_WIDTH  flit destination, {tid, tdest}.
is_tail_in  in  1  last flit of a packet.
send_in  in  1  flit valid this cycle; single-cycle qualifier with no ready.
credit_out  out  1  one-cycle pulse returning one buffer credit.
axis_out_tvalid  out  1  AXIS valid.
axis_out_tready  in  1  AXIS ready.
axis_out_tdata  out  FLIT_WIDTH  head flit payload.
axis_out_tlast  out  1  head flit is_tail.
axis_out_tid  out  TID_WIDTH  dest[DEST_WIDTH-1:TDEST_WIDTH].
axis_out_tdest  out  TDEST_WIDTH  dest[TDEST_WIDTH-1:0].
occupancy  out  $clog2(FLIT_BUFFER_DEPTH+1)  current FIFO fill.
pkt_count  out  PKT_CNT_WIDTH  number of packets fully delivered (tlast handshakes).
overflow_err  out  1  sticky flag: a flit arrived while the FIFO was full and nothing was popped.

Behaviour:
- Reset (async assert, sync deassert handled upstream): FIFO empty; occupancy=0; axis_out_tvalid=0; credit_out=0; pkt_count=0; overflow_err=0; rx_state=IDLE.
  - tdata/tlast/tid/tdest are don't-care while tvalid=0. They are driven from the head entry with no X-propagation requirement.
- FIFO entry = {data, dest, tail}. Circular buffer with read/write pointers wrapping at FLIT_BUFFER_DEPTH; the depth need not be a power of 2.
- Push occurs when send_in=1 at a clock edge.
- Pop occurs when axis_out_tvalid && axis_out_tready at an edge.
- axis_out_tvalid = (occupancy != 0). The head entry is shown combinationally from the registered FIFO (show-ahead).
- Latency: a flit sampled at edge N is visible with tvalid=1 after edge N. An empty FIFO gives a 1-cycle input-to-output latency.
- AXIS rules: tvalid never drops without a handshake, and tdata/tlast/tid/tdest are stable while tvalid && !tready.
- Credit: each pop at edge N sets credit_out=1 for exactly the cycle after edge N.
  - At most one pop per cycle, so credits never merge.
  - Total credits returned equals flits popped.
- Simultaneous push and pop: occupancy is unchanged and both operations take effect. This holds even when full, because the pop frees the slot in the same edge.
- Overflow: push while occupancy==FLIT_BUFFER_DEPTH with no same-edge pop.
  - The flit is dropped and no credit is generated for it.
  - overflow_err is set to 1 and stays set until reset.
  - FIFO contents are untouched.
- Push into an empty FIFO with tready=1 is not bypassed. The flit is popped no earlier than the next edge.
- rx_state tracks the output packet:
  - IDLE → IN_PKT on a handshake with tlast=0.
  - IN_PKT → IDLE on a handshake with tlast=1.
  - IDLE → IDLE on a handshake with tlast=1 (single-flit packet).
  - Every handshake with tlast=1 increments pkt_count, which wraps modulo 2^PKT_CNT_WIDTH.
  - The state is observable only through pkt_count.
  - The state does not stall or gate the output; it is kept for debug and assertions.
- Reset mid-packet: the FIFO is flushed and credits for flushed flits are NOT returned. The link sender must be reset in the same reset domain.

Test Plan:
- Single flit, data=0xDEADBEEF, dest=4'b1001, tail=1, tready=1 → tvalid high 1 cycle after send, tid=2'b10, tdest=2'b01, tlast=1; credit_out pulses 1 cycle after the handshake; pkt_count=1.
- Depth=2, sender sends 2 flits back-to-back with tready=0 → occupancy=2, tvalid held, data stable for 10 cycles, no credit; raise tready → 2 handshakes on consecutive cycles, 2 credit pulses on consecutive cycles, occupancy 0.
- Full FIFO, third send_in with no pop → overflow_err=1 and stays set; the third flit is never output; the first two flits are output intact in order.
- Full FIFO, send_in on the same edge as a pop → occupancy stays 2, overflow_err=0; the three flits exit in order with three credits.
- 4-flit packet (tails 0,0,0,1) then 1-flit packet, random tready (50%) → flits in order, pkt_count=2, credits=5; a model sender starting with 2 credits never overflows.
- rst_n asserted with occupancy=1 mid-packet → tvalid=0, occupancy=0, credit_out=0, pkt_count=0 immediately (asynchronous); normal operation resumes after deassert.

Source files
------------

// File: rtl/noc_flit_rx_endpoint.sv
// ---------------------------------------------------------------------------
// noc_flit_rx_endpoint
//
// Receiving end of a credit-based router-to-router flit link. Incoming flits
// land in a small circular FIFO and are presented as an AXI-Stream master.
// One credit is returned, as a single-cycle pulse, for each flit drained.
//
// Ports
//   clk_noc, rst_n           NoC clock (rising edge), async active-low reset
//   data_in/dest_in/
//   is_tail_in/send_in       flit link input; send_in qualifies one flit
//   credit_out               one-cycle pulse, one buffer slot freed
//   axis_out_*               AXI-Stream master, show-ahead from FIFO head
//                            (tid/tdest split from the flit dest field)
//   occupancy                current FIFO fill level
//   pkt_count                packets delivered (tlast handshakes), wraps
//   overflow_err             sticky: flit arrived into a full FIFO, dropped
// ---------------------------------------------------------------------------
module noc_flit_rx_endpoint #(
    parameter int FLIT_WIDTH        = 32,
    parameter int TID_WIDTH         = 2,
    parameter int TDEST_WIDTH       = 2,
    parameter int DEST_WIDTH        = TID_WIDTH + TDEST_WIDTH,
    parameter int FLIT_BUFFER_DEPTH = 2,
    parameter int PKT_CNT_WIDTH     = 16,
    localparam int OCC_WIDTH        = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                     clk_noc,
    input  logic                     rst_n,
    input  logic [FLIT_WIDTH-1:0]    data_in,
    input  logic [DEST_WIDTH-1:0]    dest_in,
    input  logic                     is_tail_in,
    input  logic                     send_in,
    output logic                     credit_out,
    output logic                     axis_out_tvalid,
    input  logic                     axis_out_tready,
    output logic [FLIT_WIDTH-1:0]    axis_out_tdata,
    output logic                     axis_out_tlast,
    output logic [TID_WIDTH-1:0]     axis_out_tid,
    output logic [TDEST_WIDTH-1:0]   axis_out_tdest,
    output logic [OCC_WIDTH-1:0]     occupancy,
    output logic [PKT_CNT_WIDTH-1:0] pkt_count,
    output logic                     overflow_err
);

    localparam int PTR_WIDTH = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;

    typedef enum logic [0:0] {
        RX_IDLE   = 1'b0,
        RX_IN_PKT = 1'b1
    } rx_state_e;

    // FIFO storage; contents need no reset since tvalid masks them.
    logic [FLIT_WIDTH-1:0] data_mem [FLIT_BUFFER_DEPTH];
    logic [DEST_WIDTH-1:0] dest_mem [FLIT_BUFFER_DEPTH];
    logic                  tail_mem [FLIT_BUFFER_DEPTH];

    logic [PTR_WIDTH-1:0]     wptr_q, wptr_d;
    logic [PTR_WIDTH-1:0]     rptr_q, rptr_d;
    logic [OCC_WIDTH-1:0]     occ_q, occ_d;
    logic                     credit_q;
    logic                     ovf_q, ovf_d;
    logic [PKT_CNT_WIDTH-1:0] pkt_q, pkt_d;
    rx_state_e                state_q, state_d;

    logic full;
    logic pop;
    logic push;
    logic [DEST_WIDTH-1:0] head_dest;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        // Explicit wrap so non-power-of-2 depths work.
        if (p == PTR_WIDTH'(FLIT_BUFFER_DEPTH - 1)) return '0;
        return p + PTR_WIDTH'(1);
    endfunction

    assign full = (occ_q == OCC_WIDTH'(FLIT_BUFFER_DEPTH));
    assign pop  = axis_out_tvalid && axis_out_tready;
    // A same-edge pop frees the slot, so a send into a full FIFO is accepted then.
    assign push = send_in && (!full || pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        occ_d   = occ_q;
        ovf_d   = ovf_q;
        pkt_d   = pkt_q;
        state_d = state_q;

        if (push) wptr_d = ptr_inc(wptr_q);
        if (pop)  rptr_d = ptr_inc(rptr_q);

        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_WIDTH'(1);
            2'b01:   occ_d = occ_q - OCC_WIDTH'(1);
            default: occ_d = occ_q;
        endcase

        if (send_in && !push) ovf_d = 1'b1;

        // Packet tracker: purely observational, never gates the stream.
        if (pop) begin
            if (axis_out_tlast) begin
                state_d = RX_IDLE;
                pkt_d   = pkt_q + PKT_CNT_WIDTH'(1);
            end else begin
                state_d = RX_IN_PKT;
            end
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            occ_q    <= '0;
            credit_q <= 1'b0;
            ovf_q    <= 1'b0;
            pkt_q    <= '0;
            state_q  <= RX_IDLE;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            occ_q    <= occ_d;
            credit_q <= pop;
            ovf_q    <= ovf_d;
            pkt_q    <= pkt_d;
            state_q  <= state_d;
        end
    end

    always_ff @(posedge clk_noc) begin
        if (push) begin
            data_mem[wptr_q] <= data_in;
            dest_mem[wptr_q] <= dest_in;
            tail_mem[wptr_q] <= is_tail_in;
        end
    end

    assign head_dest       = dest_mem[rptr_q];
    assign axis_out_tvalid = (occ_q != '0);
    assign axis_out_tdata  = data_mem[rptr_q];
    assign axis_out_tlast  = tail_mem[rptr_q];
    assign axis_out_tid    = head_dest[DEST_WIDTH-1:TDEST_WIDTH];
    assign axis_out_tdest  = head_dest[TDEST_WIDTH-1:0];
    assign credit_out      = credit_q;
    assign occupancy       = occ_q;
    assign pkt_count       = pkt_q;
    assign overflow_err    = ovf_q;

endmodule
